// File: rtl/dmem_mmio.sv
// dmem_mmio: data-side slave for the cpu core.
//   Holds the data RAM (byte-lane writes, asynchronous read) and a small MMIO
//   window with a free-running cycle counter, a console TX byte queue drained
//   by a valid/ready sink, and a sticky status register.
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   daddr  [31:0]     byte address from cpu (bits [1:0] ignored)
//   dwdata [31:0]     write data from cpu
//   dwe    [3:0]      byte-lane write enables, dwe[i] -> dwdata[8i+7:8i]
//   drdata [31:0]     combinational read data for daddr
//   tx_data [7:0]     head byte of the TX queue (0 when empty)
//   tx_valid          TX queue non-empty
//   tx_ready          sink accepts tx_data when tx_valid && tx_ready
module dmem_mmio #(
  parameter int DMEM_WORDS = 1024,
  parameter int TXQ_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dwe,
  output logic [31:0] drdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int AW = $clog2(DMEM_WORDS);
  localparam int PW = $clog2(TXQ_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [29:0]   W_CYCLE  = 30'h2000_0000;
  localparam logic [29:0]   W_TXDATA = 30'h2000_0001;
  localparam logic [29:0]   W_STATUS = 30'h2000_0002;
  localparam logic [CW-1:0] DEPTH_C  = CW'(TXQ_DEPTH);

  // Address decode (word granularity)
  logic [29:0]   widx;
  logic [AW-1:0] ram_idx;
  logic          sel_ram, sel_cyc, sel_tx, sel_st, sel_bad, any_we;
  logic          unused_addr_lsbs;

  assign widx             = daddr[31:2];
  assign ram_idx          = daddr[AW+1:2];
  assign sel_ram          = (widx < 30'(DMEM_WORDS));
  assign sel_cyc          = (widx == W_CYCLE);
  assign sel_tx           = (widx == W_TXDATA);
  assign sel_st           = (widx == W_STATUS);
  assign sel_bad          = !(sel_ram || sel_cyc || sel_tx || sel_st);
  assign any_we           = |dwe;
  assign unused_addr_lsbs = ^daddr[1:0];

  // RAM: not reset, and a store still commits while reset is asserted
  logic [31:0] ram_q [DMEM_WORDS];

  always_ff @(posedge clk) begin
    if (sel_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (dwe[i]) ram_q[ram_idx][8*i +: 8] <= dwdata[8*i +: 8];
      end
    end
  end

  // MMIO state
  logic [31:0]   cycle_q, cycle_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          bad_q, bad_d;
  logic [7:0]    txq_q [TXQ_DEPTH];

  logic full, empty, pop, push_req, push_ok;
  logic [31:0] status;

  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign pop      = !empty && tx_ready;
  assign push_req = sel_tx && dwe[0];
  // A pop in the same cycle frees the slot a push into a full queue needs
  assign push_ok  = push_req && (!full || pop);

  assign status = {14'd0, bad_q, ovf_q, 8'(count_q), 6'd0, empty, full};

  always_comb begin
    // Counter write takes priority over the increment
    cycle_d = (sel_cyc && any_we) ? 32'd0 : cycle_q + 32'd1;

    head_d = pop     ? head_q + PW'(1) : head_q;
    tail_d = push_ok ? tail_q + PW'(1) : tail_q;

    count_d = count_q;
    if (push_ok && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push_ok) count_d = count_q - CW'(1);

    ovf_d = ovf_q;
    if (push_req && !push_ok)               ovf_d = 1'b1;
    if (sel_st && dwe[2] && dwdata[16])     ovf_d = 1'b0;

    bad_d = bad_q;
    if (sel_bad && any_we)                  bad_d = 1'b1;
    if (sel_st && dwe[2] && dwdata[17])     bad_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      cycle_q <= cycle_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      bad_q   <= bad_d;
    end
  end

  // Queue storage is not reset; validity is tracked by count_q
  always_ff @(posedge clk) begin
    if (push_ok && !reset) txq_q[tail_q] <= dwdata[7:0];
  end

  // TX outputs depend on registered state only (no fall-through)
  assign tx_valid = !empty;
  assign tx_data  = empty ? 8'h00 : txq_q[head_q];

  // Combinational read mux
  always_comb begin
    drdata = '0;
    if (sel_ram)      drdata = ram_q[ram_idx];
    else if (sel_cyc) drdata = cycle_q;
    else if (sel_st)  drdata = status;
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Testbench for dmem_mmio: directed scenarios plus randomized traffic checked
// against a queue/array reference model of the data slave.
module tb_dmem_mmio;

  localparam int DMEM_WORDS = 1024;
  localparam int TXQ_DEPTH  = 8;
  localparam logic [31:0] A_CYC = 32'h8000_0000;
  localparam logic [31:0] A_TX  = 32'h8000_0004;
  localparam logic [31:0] A_ST  = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] daddr, dwdata, drdata;
  logic [3:0]  dwe;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  dmem_mmio #(.DMEM_WORDS(DMEM_WORDS), .TXQ_DEPTH(TXQ_DEPTH)) dut (
    .clk(clk), .reset(reset), .daddr(daddr), .dwdata(dwdata), .dwe(dwe),
    .drdata(drdata), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  // Reference model
  logic [31:0] m_ram [int];
  logic [31:0] m_cycle;
  logic [7:0]  m_q [$];
  logic        m_ovf, m_bad;

  function automatic logic [31:0] m_status();
    int sz;
    sz = m_q.size();
    return {14'd0, m_bad, m_ovf, 8'(sz), 6'd0, sz == 0, sz == TXQ_DEPTH};
  endfunction

  function automatic logic [31:0] m_read(logic [31:0] a);
    logic [31:0] wa;
    wa = a & ~32'h3;
    if (a < 32'(4*DMEM_WORDS))
      return m_ram.exists(int'(a >> 2)) ? m_ram[int'(a >> 2)] : 32'h0;
    if (wa == A_CYC) return m_cycle;
    if (wa == A_ST)  return m_status();
    return 32'h0;
  endfunction

  // Applies the effect of one rising edge with the inputs currently driven
  function automatic void model_edge();
    int          idx;
    logic [31:0] w, wa;
    bit          popf, wasfull, mapped;
    wa = daddr & ~32'h3;
    mapped = (daddr < 32'(4*DMEM_WORDS)) || wa == A_CYC || wa == A_TX || wa == A_ST;
    if (daddr < 32'(4*DMEM_WORDS) && dwe != 4'd0) begin
      idx = int'(daddr >> 2);
      w = m_ram.exists(idx) ? m_ram[idx] : 32'h0;
      for (int i = 0; i < 4; i++) if (dwe[i]) w[8*i +: 8] = dwdata[8*i +: 8];
      m_ram[idx] = w;
    end
    if (reset) begin
      m_cycle = 0; m_q.delete(); m_ovf = 0; m_bad = 0;
      return;
    end
    popf    = (m_q.size() != 0) && tx_ready;
    wasfull = (m_q.size() == TXQ_DEPTH);
    if (popf) void'(m_q.pop_front());
    if (wa == A_TX && dwe[0]) begin
      if (wasfull && !popf) m_ovf = 1'b1;
      else m_q.push_back(dwdata[7:0]);
    end
    if (wa == A_CYC && dwe != 4'd0) m_cycle = 32'd0;
    else m_cycle = m_cycle + 32'd1;
    if (wa == A_ST && dwe[2]) begin
      if (dwdata[16]) m_ovf = 1'b0;
      if (dwdata[17]) m_bad = 1'b0;
    end
    if (!mapped && dwe != 4'd0) m_bad = 1'b1;
  endfunction

  task automatic set_in(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    daddr = a; dwdata = d; dwe = we;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; tx_ready = 1'b0;
    set_in(32'h0, 32'h0, 4'h0);
    tick(); tick();
    reset = 1'b0;
    #1;
    n_total++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00)
      $display("FAIL reset_tx: valid=%b data=%h required valid=0 data=00", tx_valid, tx_data);
    else n_pass++;
    repeat (5) tick();
    set_in(A_CYC, 32'h0, 4'h0); #1;
    n_total++;
    if (drdata !== 32'd5) $display("FAIL reset_cycle: got %h required %h", drdata, 32'd5);
    else n_pass++;
    set_in(A_ST, 32'h0, 4'h0); #1;
    n_total++;
    if (drdata !== 32'h0000_0002) $display("FAIL reset_status: got %h required 00000002", drdata);
    else n_pass++;
  endtask

  task automatic test_ram();
    set_in(32'h10, 32'hAABB_CCDD, 4'hF); tick();
    set_in(32'h10, 32'h0000_0011, 4'b0001); #1;
    n_total++;
    if (drdata !== 32'hAABB_CCDD) $display("FAIL ram_old_word: got %h required AABBCCDD", drdata);
    else n_pass++;
    tick();
    set_in(32'h10, 32'h0, 4'h0); #1;
    n_total++;
    if (drdata !== 32'hAABB_CC11) $display("FAIL ram_lane0: got %h required AABBCC11", drdata);
    else n_pass++;
    set_in(32'h13, 32'h5500_0000, 4'b1000); tick();
    set_in(32'h11, 32'h0, 4'h0); #1;
    n_total++;
    if (drdata !== 32'h55BB_CC11) $display("FAIL ram_lane3: got %h required 55BBCC11", drdata);
    else n_pass++;
    set_in(32'hFFC, 32'h1357_9BDF, 4'hF); tick();
    set_in(32'hFFC, 32'h0, 4'h0); #1;
    n_total++;
    if (drdata !== 32'h1357_9BDF) $display("FAIL ram_top: got %h required 13579BDF", drdata);
    else n_pass++;
    // Store during reset still commits; MMIO push during reset is suppressed
    reset = 1'b1;
    set_in(32'h20, 32'hCAFE_F00D, 4'hF); tick();
    set_in(A_TX, 32'h77, 4'b0001); tick();
    reset = 1'b0;
    set_in(32'h20, 32'h0, 4'h0); #1;
    n_total++;
    if (drdata !== 32'hCAFE_F00D) $display("FAIL ram_store_in_reset: got %h required CAFEF00D", drdata);
    else n_pass++;
    n_total++;
    if (tx_valid !== 1'b0) $display("FAIL push_in_reset: tx_valid=%b required 0", tx_valid);
    else n_pass++;
  endtask

  task automatic test_tx_overflow();
    tx_ready = 1'b0;
    set_in(A_TX, 32'h41, 4'b0001); #1;
    n_total++;
    if (tx_valid !== 1'b0) $display("FAIL no_fallthrough: tx_valid=%b required 0", tx_valid);
    else n_pass++;
    for (int i = 0; i < 9; i++) begin
      set_in(A_TX, 32'h41 + i, 4'b0001);
      tick();
    end
    set_in(A_ST, 32'h0, 4'h0); #1;
    n_total++;
    if (drdata !== 32'h0001_0801) $display("FAIL ovf_status: got %h required 00010801", drdata);
    else n_pass++;
    n_total++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h41)
      $display("FAIL ovf_head: valid=%b data=%h required valid=1 data=41", tx_valid, tx_data);
    else n_pass++;
    set_in(32'h0, 32'h0, 4'h0);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_total++;
      if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + i))
        $display("FAIL drain[%0d]: valid=%b data=%h required valid=1 data=%h", i, tx_valid, tx_data, 8'(8'h41 + i));
      else n_pass++;
      tick();
    end
    tx_ready = 1'b0; #1;
    n_total++;
    if (tx_valid !== 1'b0) $display("FAIL drained_empty: tx_valid=%b required 0", tx_valid);
    else n_pass++;
  endtask

  task automatic test_badaddr();
    set_in(32'h4000_0000, 32'h1234, 4'hF); tick();
    set_in(32'h4000_0000, 32'h0, 4'h0); #1;
    n_total++;
    if (drdata !== 32'h0) $display("FAIL bad_read: got %h required 00000000", drdata);
    else n_pass++;
    set_in(A_ST, 32'h0, 4'h0); #1;
    n_total++;
    if (drdata !== 32'h0003_0002) $display("FAIL bad_status: got %h required 00030002", drdata);
    else n_pass++;
    set_in(A_ST, 32'h0003_0000, 4'b1011); tick();
    set_in(A_ST, 32'h0, 4'h0); #1;
    n_total++;
    if (drdata !== 32'h0003_0002) $display("FAIL clear_needs_lane2: got %h required 00030002", drdata);
    else n_pass++;
    set_in(A_ST, 32'h0001_0000, 4'b0100); tick();
    set_in(A_ST, 32'h0, 4'h0); #1;
    n_total++;
    if (drdata !== 32'h0002_0002) $display("FAIL clear_ovf_only: got %h required 00020002", drdata);
    else n_pass++;
    set_in(A_ST, 32'h0003_0000, 4'b0100); tick();
    set_in(32'h1000, 32'hFFFF_FFFF, 4'h0); tick();
    set_in(A_ST, 32'h0, 4'h0); #1;
    n_total++;
    if (drdata !== 32'h0000_0002) $display("FAIL clear_both: got %h required 00000002", drdata);
    else n_pass++;
    set_in(32'h1000, 32'hFFFF_FFFF, 4'b0010); tick();
    set_in(A_ST, 32'h0, 4'h0); #1;
    n_total++;
    if (drdata !== 32'h0002_0002) $display("FAIL bad_past_ram: got %h required 00020002", drdata);
    else n_pass++;
    set_in(A_TX, 32'hFFFF_FFFF, 4'h0); #1;
    n_total++;
    if (drdata !== 32'h0) $display("FAIL txdata_read: got %h required 00000000", drdata);
    else n_pass++;
    set_in(A_ST, 32'h0002_0000, 4'b0100); tick();
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_b;
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_in(A_TX, 32'h41 + i, 4'b0001);
      tick();
    end
    set_in(A_TX, 32'h5A, 4'b0001);
    tx_ready = 1'b1; #1;
    n_total++;
    if (tx_data !== 8'h41) $display("FAIL fpp_head: got %h required 41", tx_data);
    else n_pass++;
    tick();
    tx_ready = 1'b0;
    set_in(A_ST, 32'h0, 4'h0); #1;
    n_total++;
    if (drdata !== 32'h0000_0801) $display("FAIL fpp_status: got %h required 00000801", drdata);
    else n_pass++;
    set_in(32'h0, 32'h0, 4'h0);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_b = (i == 7) ? 8'h5A : 8'(8'h42 + i);
      #1;
      n_total++;
      if (tx_valid !== 1'b1 || tx_data !== exp_b)
        $display("FAIL fpp_drain[%0d]: valid=%b data=%h required valid=1 data=%h", i, tx_valid, tx_data, exp_b);
      else n_pass++;
      tick();
    end
    tx_ready = 1'b0; #1;
    n_total++;
    if (tx_valid !== 1'b0) $display("FAIL fpp_empty: tx_valid=%b required 0", tx_valid);
    else n_pass++;
  endtask

  task automatic test_cycle();
    set_in(A_CYC, 32'h0, 4'h0);
    repeat (3) tick();
    #1;
    n_total++;
    if (drdata !== m_cycle) $display("FAIL cycle_run: got %h required %h", drdata, m_cycle);
    else n_pass++;
    set_in(A_CYC, 32'hFFFF_FFFF, 4'b0010); tick();
    set_in(A_CYC, 32'h0, 4'h0); #1;
    n_total++;
    if (drdata !== 32'd0) $display("FAIL cycle_clr0: got %h required 00000000", drdata);
    else n_pass++;
    tick();
    n_total++;
    if (drdata !== 32'd1) $display("FAIL cycle_clr1: got %h required 00000001", drdata);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] a, exp_d;
    logic [7:0]  exp_t;
    int          sel;
    for (int i = 0; i < 8; i++) begin
      set_in(32'(4*i), $urandom, 4'hF); tick();
    end
    set_in(32'hFFC, $urandom, 4'hF); tick();
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3: a = 32'(4*$urandom_range(0, 7)) | 32'($urandom_range(0, 3));
        4:          a = 32'hFFC;
        5:          a = A_CYC;
        6:          a = A_TX;
        7:          a = A_ST;
        8:          a = 32'h8000_000C;
        default:    a = 32'h4000_0000 | 32'($urandom_range(0, 255));
      endcase
      set_in(a, $urandom, ($urandom_range(0, 1) == 1) ? 4'(int'($urandom_range(0, 15))) : 4'h0);
      tx_ready = ($urandom_range(0, 2) == 0);
      reset = ($urandom_range(0, 63) == 0);
      #1;
      exp_d = m_read(a);
      exp_t = (m_q.size() != 0) ? m_q[0] : 8'h00;
      n_total++;
      if (drdata !== exp_d) $display("FAIL rnd_drdata[%0d] addr=%h: got %h required %h", n, a, drdata, exp_d);
      else n_pass++;
      n_total++;
      if (tx_valid !== (m_q.size() != 0) || tx_data !== exp_t)
        $display("FAIL rnd_tx[%0d]: valid=%b data=%h required valid=%b data=%h", n, tx_valid, tx_data, m_q.size() != 0, exp_t);
      else n_pass++;
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tx_ready = 1'b0;
    set_in(32'h0, 32'h0, 4'h0);
    test_reset();
    test_ram();
    test_tx_overflow();
    test_badaddr();
    test_full_push_pop();
    test_cycle();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
